// File: rtl/mem_ctrl_if.sv
// Bus bundle between the memory controller, its two requesters (icache, LSU)
// and the byte-wide unified RAM. The controller takes the slave view; the
// requester/RAM environment takes the master view.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
) ();
    // instruction fetch side
    logic              inst_require_i;
    logic [ADDR_W-1:0] inst_addr_i;
    logic              flush_i;
    logic              inst_busy_o;
    logic              inst_enable_o;
    logic [31:0]       inst_data_o;
    // load/store side
    logic              mem_require_i;
    logic              mem_we_i;
    logic [1:0]        mem_len_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [31:0]       mem_data_i;
    logic              mem_enable_o;
    logic [31:0]       mem_data_o;
    // RAM side
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;

    modport slave (
        input  inst_require_i, inst_addr_i, flush_i,
        input  mem_require_i, mem_we_i, mem_len_i, mem_addr_i, mem_data_i,
        input  ram_din,
        output inst_busy_o, inst_enable_o, inst_data_o,
        output mem_enable_o, mem_data_o,
        output ram_dout, ram_a, ram_wr
    );

    modport master (
        output inst_require_i, inst_addr_i, flush_i,
        output mem_require_i, mem_we_i, mem_len_i, mem_addr_i, mem_data_i,
        output ram_din,
        input  inst_busy_o, inst_enable_o, inst_data_o,
        input  mem_enable_o, mem_data_o,
        input  ram_dout, ram_a, ram_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: serves one icache word fetch or one LSU
// 1/2/4-byte load/store at a time over an 8-bit RAM with one cycle read
// latency. Words are assembled/disassembled little-endian and every
// completion is a registered one-cycle pulse.
module mem_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DATA_PRIO = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    mem_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        INST_RD = 2'd1,
        DATA_RD = 2'd2,
        DATA_WR = 2'd3
    } state_t;

    state_t            state;
    logic [2:0]        cnt;       // cycles spent in the current transfer, 0 in T1
    logic [ADDR_W-1:0] addr;      // latched base address
    logic [1:0]        last;      // index of the final byte (N-1)
    logic [31:0]       wdata;     // store data, shifted down one byte per issue
    logic [31:0]       rbuf;      // partially assembled read word
    logic              rdy_q;     // rdy of the previous cycle
    logic [7:0]        din_hold;  // RAM byte seen in the first stalled cycle

    logic              take_data;
    logic              take_inst;
    logic [1:0]        len_fix;
    logic [7:0]        din;
    logic [2:0]        last_x;
    logic [1:0]        next_k;
    logic [1:0]        cap_k;
    logic [31:0]       merged;
    logic [ADDR_W-1:0] next_addr;

    // Arbitration, length decode and read-byte merging
    always_comb begin
        take_data = bus.mem_require_i && ((DATA_PRIO != 0) || !bus.inst_require_i);
        take_inst = bus.inst_require_i && !take_data;
        len_fix   = (bus.mem_len_i == 2'd2) ? 2'd3 : bus.mem_len_i;
        // after a stall the RAM output has moved on; use the byte held at stall entry
        din       = rdy_q ? bus.ram_din : din_hold;
        last_x    = {1'b0, last};
        next_k    = cnt[1:0] + 2'd1;
        cap_k     = cnt[1:0] - 2'd1;
        merged    = rbuf | ({24'd0, din} << {cap_k, 3'b000});
        next_addr = addr + {{(ADDR_W-2){1'b0}}, next_k};
    end

    // Track stalls so the byte due at the next enabled edge is not lost
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_q    <= 1'b1;
            din_hold <= 8'd0;
        end else begin
            rdy_q <= rdy;
            if (rdy_q && !rdy)
                din_hold <= bus.ram_din;
        end
    end

    // Transfer FSM with all outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            cnt               <= 3'd0;
            addr              <= '0;
            last              <= 2'd0;
            wdata             <= 32'd0;
            rbuf              <= 32'd0;
            bus.inst_busy_o   <= 1'b0;
            bus.inst_enable_o <= 1'b0;
            bus.inst_data_o   <= 32'd0;
            bus.mem_enable_o  <= 1'b0;
            bus.mem_data_o    <= 32'd0;
            bus.ram_a         <= '0;
            bus.ram_dout      <= 8'd0;
            bus.ram_wr        <= 1'b0;
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    cnt  <= 3'd0;
                    rbuf <= 32'd0;
                    if (take_data) begin
                        addr            <= bus.mem_addr_i;
                        last            <= len_fix;
                        wdata           <= bus.mem_data_i;
                        bus.ram_a       <= bus.mem_addr_i;
                        bus.inst_busy_o <= 1'b1;
                        if (bus.mem_we_i) begin
                            state        <= DATA_WR;
                            bus.ram_dout <= bus.mem_data_i[7:0];
                            bus.ram_wr   <= 1'b1;
                        end else begin
                            state <= DATA_RD;
                        end
                    end else if (take_inst) begin
                        addr            <= bus.inst_addr_i;
                        last            <= 2'd3;
                        bus.ram_a       <= bus.inst_addr_i;
                        bus.inst_busy_o <= 1'b1;
                        state           <= INST_RD;
                    end
                end
                INST_RD, DATA_RD: begin
                    if (state == INST_RD && bus.flush_i) begin
                        state             <= IDLE;
                        bus.inst_busy_o   <= 1'b0;
                        bus.inst_enable_o <= 1'b0;
                    end else if (cnt == last_x + 3'd2) begin
                        state             <= IDLE;
                        bus.inst_busy_o   <= 1'b0;
                        bus.inst_enable_o <= 1'b0;
                        bus.mem_enable_o  <= 1'b0;
                    end else begin
                        cnt <= cnt + 3'd1;
                        if (cnt < last_x)
                            bus.ram_a <= next_addr;
                        if (cnt == last_x + 3'd1) begin
                            if (state == INST_RD) begin
                                bus.inst_data_o   <= merged;
                                bus.inst_enable_o <= 1'b1;
                            end else begin
                                bus.mem_data_o    <= merged;
                                bus.mem_enable_o  <= 1'b1;
                            end
                        end else if (cnt != 3'd0) begin
                            rbuf <= merged;
                        end
                    end
                end
                DATA_WR: begin
                    if (cnt == last_x + 3'd1) begin
                        state            <= IDLE;
                        bus.inst_busy_o  <= 1'b0;
                        bus.mem_enable_o <= 1'b0;
                    end else begin
                        cnt <= cnt + 3'd1;
                        if (cnt < last_x) begin
                            bus.ram_a    <= next_addr;
                            bus.ram_dout <= wdata[15:8];
                            wdata        <= wdata >> 8;
                        end else begin
                            bus.ram_wr       <= 1'b0;
                            bus.mem_enable_o <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: table of transactions through a scoreboard, a byte RAM
// model with one cycle read latency, and hand sequences for flush and reset.
module tb_mem_ctrl;
    localparam int K_INST  = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;

    typedef struct {
        string       name;
        int          kind;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
        bit          dual;
        bit          flush0;
        int          stall;
    } vec_t;

    typedef struct {
        int          kind;
        logic [31:0] data;
        int          lat;
        string       name;
    } exp_t;

    logic clk;
    logic rst;
    logic rdy;
    mem_ctrl_if #(.ADDR_W(32)) bus ();

    mem_ctrl #(.ADDR_W(32), .DATA_PRIO(1)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb[$];
    logic [39:0] wlog[$];
    logic [31:0] last_load = 32'd0;
    logic [31:0] last_inst = 32'd0;
    vec_t        vecs[15];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte RAM: registered read of the address driven in the previous cycle
    logic [7:0] ram_m [0:65535];
    bit         preloaded = 1'b0;
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 65536; i++) ram_m[i] <= 8'h00;
            ram_m[16'h1000] <= 8'h13; ram_m[16'h1001] <= 8'h05;
            ram_m[16'h1002] <= 8'h00; ram_m[16'h1003] <= 8'h00;
            ram_m[16'h2000] <= 8'h93; ram_m[16'h2001] <= 8'h00;
            ram_m[16'h2002] <= 8'h10; ram_m[16'h2003] <= 8'h00;
            ram_m[16'h0040] <= 8'h11; ram_m[16'h0041] <= 8'h22;
            ram_m[16'h0042] <= 8'h33; ram_m[16'h0043] <= 8'h44;
            preloaded <= 1'b1;
        end else if (bus.ram_wr) begin
            ram_m[bus.ram_a[15:0]] <= bus.ram_dout;
        end
        bus.ram_din <= ram_m[bus.ram_a[15:0]];
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input int kind, input logic [1:0] len,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp, input int lat, input bit dual,
                                input bit flush0, input int stall);
        vec_t v;
        v.name = nm; v.kind = kind; v.len = len; v.addr = addr; v.wdata = wdata;
        v.exp = exp; v.lat = lat; v.dual = dual; v.flush0 = flush0; v.stall = stall;
        return v;
    endfunction

    // Entered and left just after a rising edge with the controller idle
    task automatic issue(input vec_t v);
        exp_t e;
        int   t;
        int   n;
        bit   got;
        bit   busy_ok;
        e.kind = v.kind;
        e.lat  = v.lat;
        e.data = (v.kind == K_STORE) ? last_load : v.exp;
        e.name = v.name;
        sb.push_back(e);
        wlog.delete();
        n = (v.len == 2'd2) ? 4 : int'(v.len) + 1;
        if (v.kind == K_INST) begin
            bus.inst_require_i = 1'b1;
            bus.inst_addr_i    = v.addr;
        end else begin
            bus.mem_require_i = 1'b1;
            bus.mem_we_i      = (v.kind == K_STORE);
            bus.mem_len_i     = v.len;
            bus.mem_addr_i    = v.addr;
            bus.mem_data_i    = v.wdata;
            if (v.dual) begin
                bus.inst_require_i = 1'b1;
                bus.inst_addr_i    = 32'h1000;
            end
        end
        bus.flush_i = v.flush0;
        @(posedge clk); #1;
        bus.inst_require_i = 1'b0;
        bus.flush_i        = 1'b0;
        t = 1; got = 1'b0; busy_ok = 1'b1;
        while (!got && t < 30) begin
            if (v.stall != 0 && t == v.stall)     rdy = 1'b0;
            if (v.stall != 0 && t == v.stall + 3) rdy = 1'b1;
            @(negedge clk);
            busy_ok = busy_ok & bus.inst_busy_o;
            if (bus.ram_wr) wlog.push_back({bus.ram_a, bus.ram_dout});
            if (bus.inst_enable_o || bus.mem_enable_o) got = 1'b1;
            else begin
                @(posedge clk); #1;
                t++;
            end
        end
        rdy = 1'b1;
        e = sb.pop_front();
        check({e.name, "_done"}, 64'(got), 64'd1);
        check({e.name, "_pulse"}, {62'd0, bus.inst_enable_o, bus.mem_enable_o},
              (e.kind == K_INST) ? 64'd2 : 64'd1);
        check({e.name, "_data"}, (e.kind == K_INST) ? 64'(bus.inst_data_o) : 64'(bus.mem_data_o),
              64'(e.data));
        check({e.name, "_lat"}, 64'(t), 64'(e.lat));
        check({e.name, "_busy"}, 64'(busy_ok), 64'd1);
        if (v.kind == K_STORE) begin
            check({e.name, "_wrcount"}, 64'(wlog.size()), 64'(n));
            for (int k = 0; k < n; k++)
                if (k < wlog.size())
                    check({e.name, "_wrbyte"}, 64'(wlog[k]),
                          64'({v.addr + 32'(k), 8'(v.wdata >> (8 * k))}));
        end
        bus.mem_require_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check({e.name, "_idle"}, {61'd0, bus.inst_busy_o, bus.inst_enable_o, bus.mem_enable_o}, 64'd0);
        @(posedge clk); #1;
        if (v.kind == K_LOAD) last_load = v.exp;
        if (v.kind == K_INST) last_inst = v.exp;
        $display("txn %-12s kind=%0d addr=%h exp=%h lat=%0d", e.name, e.kind, v.addr, e.data, t);
    endtask

    initial begin
        vec_t v;
        bit   seen;
        vecs[0]  = mk("fetch1000", K_INST,  2'd3, 32'h0000_1000, 32'h0,         32'h0000_0513, 6, 0, 0, 0);
        vecs[1]  = mk("st_word20", K_STORE, 2'd3, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0,         5, 0, 0, 0);
        vecs[2]  = mk("ld_byte21", K_LOAD,  2'd0, 32'h0000_0021, 32'h0,         32'h0000_00BE, 3, 0, 0, 0);
        vecs[3]  = mk("ld_half22", K_LOAD,  2'd1, 32'h0000_0022, 32'h0,         32'h0000_DEAD, 4, 0, 0, 0);
        vecs[4]  = mk("ld_dual40", K_LOAD,  2'd3, 32'h0000_0040, 32'h0,         32'h4433_2211, 6, 1, 0, 0);
        vecs[5]  = mk("refetch",   K_INST,  2'd3, 32'h0000_1000, 32'h0,         32'h0000_0513, 6, 0, 0, 0);
        vecs[6]  = mk("ld_stall",  K_LOAD,  2'd3, 32'h0000_0020, 32'h0,         32'hDEAD_BEEF, 9, 0, 0, 3);
        vecs[7]  = mk("st_byte30", K_STORE, 2'd0, 32'h0000_0030, 32'h0000_0055, 32'h0,         2, 0, 0, 0);
        vecs[8]  = mk("st_half32", K_STORE, 2'd1, 32'h0000_0032, 32'h0000_1234, 32'h0,         3, 0, 0, 0);
        vecs[9]  = mk("ld_len2_30",K_LOAD,  2'd2, 32'h0000_0030, 32'h0,         32'h1234_0055, 6, 0, 0, 0);
        vecs[10] = mk("st_wrap",   K_STORE, 2'd3, 32'hFFFF_FFFE, 32'hA1B2_C3D4, 32'h0,         5, 0, 0, 0);
        vecs[11] = mk("ld_wrap",   K_LOAD,  2'd3, 32'hFFFF_FFFF, 32'h0,         32'h00A1_B2C3, 6, 0, 0, 0);
        vecs[12] = mk("ld_half0",  K_LOAD,  2'd1, 32'h0000_0000, 32'h0,         32'h0000_A1B2, 4, 0, 0, 0);
        vecs[13] = mk("fetch_fl",  K_INST,  2'd3, 32'h0000_2000, 32'h0,         32'h0010_0093, 6, 0, 1, 0);
        vecs[14] = mk("ld_byte23", K_LOAD,  2'd0, 32'h0000_0023, 32'h0,         32'h0000_00DE, 3, 0, 0, 0);

        rst = 1'b0; rdy = 1'b1;
        bus.inst_require_i = 1'b0; bus.inst_addr_i = 32'd0; bus.flush_i = 1'b0;
        bus.mem_require_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_len_i = 2'd0;
        bus.mem_addr_i = 32'd0; bus.mem_data_i = 32'd0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy",      64'(bus.inst_busy_o),   64'd0);
        check("rst_inst_en",   64'(bus.inst_enable_o), 64'd0);
        check("rst_inst_data", 64'(bus.inst_data_o),   64'd0);
        check("rst_mem_en",    64'(bus.mem_enable_o),  64'd0);
        check("rst_mem_data",  64'(bus.mem_data_o),    64'd0);
        check("rst_ram_a",     64'(bus.ram_a),         64'd0);
        check("rst_ram_dout",  64'(bus.ram_dout),      64'd0);
        check("rst_ram_wr",    64'(bus.ram_wr),        64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) issue(vecs[i]);

        // flush in T3 of a fetch: no pulse, idle in T4, old word kept
        bus.inst_require_i = 1'b1; bus.inst_addr_i = 32'h1000;
        @(posedge clk); #1;
        bus.inst_require_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.flush_i = 1'b1;
        @(negedge clk);
        check("flush_busy_t3", 64'(bus.inst_busy_o), 64'd1);
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        @(negedge clk);
        check("flush_idle_t4", 64'(bus.inst_busy_o), 64'd0);
        seen = bus.inst_enable_o;
        repeat (8) begin
            @(negedge clk);
            seen = seen | bus.inst_enable_o;
        end
        check("flush_no_pulse", 64'(seen), 64'd0);
        check("flush_hold", 64'(bus.inst_data_o), 64'(last_inst));
        $display("txn %-12s flush of fetch 0x1000 at T3", "flush_seq");
        @(posedge clk); #1;
        v = mk("fetch2000", K_INST, 2'd3, 32'h0000_2000, 32'h0, 32'h0010_0093, 6, 0, 0, 0);
        issue(v);

        // reset in the middle of a store
        bus.mem_require_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_len_i = 2'd3;
        bus.mem_addr_i = 32'h50; bus.mem_data_i = 32'h0102_0304;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rstmid_ctl", {60'd0, bus.inst_busy_o, bus.inst_enable_o, bus.mem_enable_o, bus.ram_wr}, 64'd0);
        check("rstmid_inst_data", 64'(bus.inst_data_o), 64'd0);
        check("rstmid_mem_data",  64'(bus.mem_data_o),  64'd0);
        check("rstmid_ram_a",     64'(bus.ram_a),       64'd0);
        check("rstmid_ram_dout",  64'(bus.ram_dout),    64'd0);
        bus.mem_require_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        last_load = 32'd0;
        last_inst = 32'd0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rstmid_idle", {62'd0, bus.inst_busy_o, bus.ram_wr}, 64'd0);
        $display("txn %-12s reset during store to 0x50", "reset_seq");
        @(posedge clk); #1;
        v = mk("ld_after_rst", K_LOAD, 2'd3, 32'h0000_0020, 32'h0, 32'hDEAD_BEEF, 6, 0, 0, 0);
        issue(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
